// File: rtl/ppg_pkg.sv
// Shared types and constants for the PPG window statistics stage.
// Holds the FSM encoding, ADC width, tracker reset values and the AC/DC helpers.
package ppg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } ppg_state_t;

    localparam int ADC_W          = 8;
    localparam int DEFAULT_WINDOW = 500;

    localparam logic [ADC_W-1:0] MIN_INIT = {ADC_W{1'b1}};
    localparam logic [ADC_W-1:0] MAX_INIT = '0;

    function automatic logic [ADC_W-1:0] calc_ac(input logic [ADC_W-1:0] mx,
                                                 input logic [ADC_W-1:0] mn);
        return mx - mn;
    endfunction

    // The sum needs one extra bit so (255 + 255) >> 1 still yields 255.
    function automatic logic [ADC_W-1:0] calc_dc(input logic [ADC_W-1:0] mx,
                                                 input logic [ADC_W-1:0] mn);
        logic [ADC_W:0] sum;
        sum = {1'b0, mx} + {1'b0, mn};
        return sum[ADC_W:1];
    endfunction

endpackage

// File: rtl/ppg_window_stats_if.sv
// Sample stream and result bus between the LED/PGA controller side and the stats stage.
// Master drives samples and enable; slave (the stats stage) drives results and status.
interface ppg_window_stats_if;
    import ppg_pkg::*;

    logic             enable;
    logic             sample_valid;
    logic             sample_is_red;
    logic [ADC_W-1:0] sample;
    logic [ADC_W-1:0] ac_red;
    logic [ADC_W-1:0] dc_red;
    logic [ADC_W-1:0] ac_ir;
    logic [ADC_W-1:0] dc_ir;
    logic             result_valid;
    logic [7:0]       window_count;
    logic             busy;

    modport master (
        output enable, sample_valid, sample_is_red, sample,
        input  ac_red, dc_red, ac_ir, dc_ir, result_valid, window_count, busy
    );

    modport slave (
        input  enable, sample_valid, sample_is_red, sample,
        output ac_red, dc_red, ac_ir, dc_ir, result_valid, window_count, busy
    );

endinterface

// File: rtl/ppg_channel_tracker.sv
// Min/max/count tracker for one PPG channel over a window.
// Clear takes priority over accept so an aborted or published window never leaks samples.
module ppg_channel_tracker
    import ppg_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = 10
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] min,
    output logic [ADC_W-1:0] max,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    // Non-exclusive compares let the first sample set both min and max.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            min   <= MIN_INIT;
            max   <= MAX_INIT;
            count <= '0;
        end else if (clear) begin
            min   <= MIN_INIT;
            max   <= MAX_INIT;
            count <= '0;
        end else if (accept) begin
            if (sample <= min) begin
                min <= sample;
            end
            if (sample >= max) begin
                max <= sample;
            end
            count <= count + CNT_W'(1);
        end
    end

    assign full = (count == CNT_W'(WINDOW));

endmodule

// File: rtl/ppg_window_stats.sv
// Per-channel window min/max statistics, publishing AC amplitude and DC level per window.
// Top level owns the FSM, result registers and saturating window counter.
module ppg_window_stats
    import ppg_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = 10
) (
    input  logic                CLK,
    input  logic                rst_n,
    ppg_window_stats_if.slave   bus
);

    ppg_state_t       state;
    logic             tracker_clear;
    logic             accept_red;
    logic             accept_ir;
    logic             red_done;
    logic             ir_done;
    logic             window_done;
    logic [ADC_W-1:0] red_min;
    logic [ADC_W-1:0] red_max;
    logic [ADC_W-1:0] ir_min;
    logic [ADC_W-1:0] ir_max;
    logic [CNT_W-1:0] red_count;
    logic [CNT_W-1:0] ir_count;
    logic             red_full;
    logic             ir_full;

    assign tracker_clear = (state != ACCUM) || !bus.enable;
    assign accept_red    = bus.sample_valid && (state == ACCUM) &&  bus.sample_is_red && !red_full;
    assign accept_ir     = bus.sample_valid && (state == ACCUM) && !bus.sample_is_red && !ir_full;

    // Look one sample ahead: a channel is done if already full or this sample fills it.
    assign red_done    = red_full || (accept_red && (red_count == CNT_W'(WINDOW - 1)));
    assign ir_done     = ir_full  || (accept_ir  && (ir_count  == CNT_W'(WINDOW - 1)));
    assign window_done = (accept_red || accept_ir) && red_done && ir_done;

    ppg_channel_tracker #(.WINDOW(WINDOW), .CNT_W(CNT_W)) u_red (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .clear  (tracker_clear),
        .accept (accept_red),
        .sample (bus.sample),
        .min    (red_min),
        .max    (red_max),
        .count  (red_count),
        .full   (red_full)
    );

    ppg_channel_tracker #(.WINDOW(WINDOW), .CNT_W(CNT_W)) u_ir (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .clear  (tracker_clear),
        .accept (accept_ir),
        .sample (bus.sample),
        .min    (ir_min),
        .max    (ir_max),
        .count  (ir_count),
        .full   (ir_full)
    );

    // Dropping enable wins over everything, including a pending publish.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.ac_red       <= '0;
            bus.dc_red       <= '0;
            bus.ac_ir        <= '0;
            bus.dc_ir        <= '0;
            bus.result_valid <= 1'b0;
            bus.window_count <= '0;
            bus.busy         <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (!bus.enable) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ACCUM;
                        bus.busy <= 1'b1;
                    end
                    ACCUM: begin
                        bus.busy <= 1'b1;
                        if (window_done) begin
                            state <= PUBLISH;
                        end
                    end
                    PUBLISH: begin
                        state            <= ACCUM;
                        bus.busy         <= 1'b1;
                        bus.ac_red       <= calc_ac(red_max, red_min);
                        bus.dc_red       <= calc_dc(red_max, red_min);
                        bus.ac_ir        <= calc_ac(ir_max, ir_min);
                        bus.dc_ir        <= calc_dc(ir_max, ir_min);
                        bus.result_valid <= 1'b1;
                        if (bus.window_count != 8'hFF) begin
                            bus.window_count <= bus.window_count + 8'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppg_window_stats.sv
// Self-checking bench for ppg_window_stats with a 4-sample window.
// Expected results are queued when a window is driven and popped when result_valid pulses.
module tb_ppg_window_stats;
    import ppg_pkg::*;

    localparam int WIN = 4;
    localparam int GAP = 2;

    typedef struct {
        logic [7:0] red [WIN];
        logic [7:0] ir  [WIN];
        logic [7:0] ac_red;
        logic [7:0] dc_red;
        logic [7:0] ac_ir;
        logic [7:0] dc_ir;
    } vec_t;

    typedef struct {
        logic [7:0] ac_red;
        logic [7:0] dc_red;
        logic [7:0] ac_ir;
        logic [7:0] dc_ir;
    } res_t;

    logic CLK;
    logic rst_n;

    int   assertions;
    int   failures;
    int   exp_wc;
    logic prev_rv;
    res_t exp_q[$];
    res_t last_res;
    res_t mon_e;
    vec_t tv[6];

    ppg_window_stats_if bus ();

    ppg_window_stats #(.WINDOW(WIN), .CNT_W(10)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mkVec(input int r0, input int r1, input int r2, input int r3,
                                   input int i0, input int i1, input int i2, input int i3,
                                   input int acr, input int dcr, input int aci, input int dci);
        vec_t v;
        v.red[0] = 8'(r0); v.red[1] = 8'(r1); v.red[2] = 8'(r2); v.red[3] = 8'(r3);
        v.ir[0]  = 8'(i0); v.ir[1]  = 8'(i1); v.ir[2]  = 8'(i2); v.ir[3]  = 8'(i3);
        v.ac_red = 8'(acr); v.dc_red = 8'(dcr); v.ac_ir = 8'(aci); v.dc_ir = 8'(dci);
        return v;
    endfunction

    // Random window with expectations from plain integer min/max arithmetic.
    function automatic vec_t randVec();
        vec_t v;
        int rmx, rmn, imx, imn;
        rmx = 0; rmn = 255; imx = 0; imn = 255;
        for (int i = 0; i < WIN; i++) begin
            v.red[i] = 8'($urandom_range(0, 255));
            v.ir[i]  = 8'($urandom_range(0, 255));
            if (int'(v.red[i]) > rmx) rmx = int'(v.red[i]);
            if (int'(v.red[i]) < rmn) rmn = int'(v.red[i]);
            if (int'(v.ir[i])  > imx) imx = int'(v.ir[i]);
            if (int'(v.ir[i])  < imn) imn = int'(v.ir[i]);
        end
        v.ac_red = 8'(rmx - rmn);
        v.dc_red = 8'((rmx + rmn) / 2);
        v.ac_ir  = 8'(imx - imn);
        v.dc_ir  = 8'((imx + imn) / 2);
        return v;
    endfunction

    function automatic res_t toRes(input vec_t v);
        res_t r;
        r.ac_red = v.ac_red; r.dc_red = v.dc_red; r.ac_ir = v.ac_ir; r.dc_ir = v.dc_ir;
        return r;
    endfunction

    always @(negedge CLK) begin
        if (rst_n && bus.result_valid) begin
            checkOutput("rv_single_cycle", int'(prev_rv), 0);
            checkOutput("publish_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e  = exp_q.pop_front();
                exp_wc = (exp_wc == 255) ? 255 : exp_wc + 1;
                checkOutput("ac_red", int'(bus.ac_red), int'(mon_e.ac_red));
                checkOutput("dc_red", int'(bus.dc_red), int'(mon_e.dc_red));
                checkOutput("ac_ir",  int'(bus.ac_ir),  int'(mon_e.ac_ir));
                checkOutput("dc_ir",  int'(bus.dc_ir),  int'(mon_e.dc_ir));
                checkOutput("window_count", int'(bus.window_count), exp_wc);
                last_res = mon_e;
            end
        end
        prev_rv = bus.result_valid;
    end

    task automatic driveSample(input logic is_red, input logic [7:0] value);
        @(negedge CLK);
        bus.sample_valid  = 1'b1;
        bus.sample_is_red = is_red;
        bus.sample        = value;
        @(negedge CLK);
        bus.sample_valid  = 1'b0;
    endtask

    task automatic driveWindow(input vec_t v);
        for (int i = 0; i < WIN; i++) begin
            driveSample(1'b1, v.red[i]);
            repeat (GAP) @(negedge CLK);
            driveSample(1'b0, v.ir[i]);
            if (i != WIN - 1) repeat (GAP) @(negedge CLK);
        end
    endtask

    // Called right after the completing sample: pulse must appear exactly one cycle later.
    task automatic checkPublish();
        checkOutput("rv_early", int'(bus.result_valid), 0);
        @(negedge CLK);
        checkOutput("rv_latency", int'(bus.result_valid), 1);
        @(negedge CLK);
        checkOutput("rv_width", int'(bus.result_valid), 0);
        checkOutput("publish_drained", exp_q.size(), 0);
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_q.push_back(toRes(v));
        driveWindow(v);
        checkPublish();
    endtask

    task automatic checkHold(input string tag);
        checkOutput({tag, "_ac_red"}, int'(bus.ac_red), int'(last_res.ac_red));
        checkOutput({tag, "_dc_red"}, int'(bus.dc_red), int'(last_res.dc_red));
        checkOutput({tag, "_ac_ir"},  int'(bus.ac_ir),  int'(last_res.ac_ir));
        checkOutput({tag, "_dc_ir"},  int'(bus.dc_ir),  int'(last_res.dc_ir));
        checkOutput({tag, "_busy"},   int'(bus.busy),   0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ac_red"}, int'(bus.ac_red), 0);
        checkOutput({tag, "_dc_red"}, int'(bus.dc_red), 0);
        checkOutput({tag, "_ac_ir"},  int'(bus.ac_ir),  0);
        checkOutput({tag, "_dc_ir"},  int'(bus.dc_ir),  0);
        checkOutput({tag, "_rv"},     int'(bus.result_valid), 0);
        checkOutput({tag, "_wc"},     int'(bus.window_count), 0);
        checkOutput({tag, "_busy"},   int'(bus.busy),   0);
    endtask

    initial begin
        res_t e;
        assertions        = 0;
        failures          = 0;
        exp_wc            = 0;
        prev_rv           = 1'b0;
        rst_n             = 1'b0;
        bus.enable        = 1'b0;
        bus.sample_valid  = 1'b0;
        bus.sample_is_red = 1'b0;
        bus.sample        = '0;
        last_res          = '{8'd0, 8'd0, 8'd0, 8'd0};

        tv[0] = mkVec(100, 140, 120, 130,  50,  60,  55,  58,  40, 120,  10,  55);
        tv[1] = mkVec(255, 255, 255, 255, 255, 255, 255, 255,   0, 255,   0, 255);
        tv[2] = mkVec(  0, 255,  10,  20, 255,   0, 128,   1, 255, 127, 255, 127);
        tv[3] = mkVec(  7,   7,   7,   7,   1,   2,   3,   4,   0,   7,   3,   2);
        tv[4] = mkVec(200, 150, 100,  50,   9,  10,   9,  10, 150, 125,   1,   9);
        tv[5] = mkVec(201,   3,  77,  90,  33,  34, 250, 251, 198, 102, 218, 142);

        repeat (2) @(negedge CLK);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge CLK);
        bus.enable = 1'b1;
        @(negedge CLK);
        checkOutput("busy_accum", int'(bus.busy), 1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tv[i]);
        end

        $display("[TB] Uneven channels: extra RED sample must be dropped");
        exp_q.push_back(toRes(tv[0]));
        for (int i = 0; i < WIN; i++) begin
            driveSample(1'b1, tv[0].red[i]);
            repeat (GAP) @(negedge CLK);
        end
        driveSample(1'b1, 8'd0);
        repeat (GAP) @(negedge CLK);
        for (int i = 0; i < WIN; i++) begin
            driveSample(1'b0, tv[0].ir[i]);
            if (i != WIN - 1) repeat (GAP) @(negedge CLK);
        end
        checkPublish();

        $display("[TB] Abort after two RED samples");
        driveSample(1'b1, 8'd10);
        repeat (GAP) @(negedge CLK);
        driveSample(1'b1, 8'd20);
        bus.enable = 1'b0;
        repeat (3) @(negedge CLK);
        checkHold("abort_hold");
        bus.enable = 1'b1;
        @(negedge CLK);
        applyStimulus(tv[5]);

        $display("[TB] Enable dropped during PUBLISH");
        driveWindow(tv[1]);
        bus.enable = 1'b0;
        repeat (3) @(negedge CLK);
        checkHold("pub_abort_hold");
        bus.enable = 1'b1;
        repeat (2) @(negedge CLK);

        $display("[TB] Sample presented in the PUBLISH cycle");
        exp_q.push_back(toRes(tv[0]));
        for (int i = 0; i < WIN; i++) begin
            driveSample(1'b1, tv[0].red[i]);
            repeat (GAP) @(negedge CLK);
            if (i != WIN - 1) begin
                driveSample(1'b0, tv[0].ir[i]);
                repeat (GAP) @(negedge CLK);
            end
        end
        @(negedge CLK);
        bus.sample_valid  = 1'b1;
        bus.sample_is_red = 1'b0;
        bus.sample        = tv[0].ir[WIN-1];
        @(negedge CLK);
        bus.sample_is_red = 1'b1;
        bus.sample        = 8'd0;
        @(negedge CLK);
        bus.sample_valid  = 1'b0;
        checkOutput("drop_rv", int'(bus.result_valid), 1);
        repeat (GAP) @(negedge CLK);
        applyStimulus(mkVec(100, 110, 120, 130, 1, 2, 3, 4, 30, 115, 3, 2));

        $display("[TB] Asynchronous reset mid-window");
        driveSample(1'b1, 8'd33);
        repeat (GAP) @(negedge CLK);
        @(posedge CLK);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        exp_q.delete();
        exp_wc   = 0;
        last_res = '{8'd0, 8'd0, 8'd0, 8'd0};
        @(negedge CLK);
        rst_n = 1'b1;
        applyStimulus(tv[3]);
        checkOutput("wc_after_reset", int'(bus.window_count), 1);

        $display("[TB] Window counter saturation");
        for (int w = 0; w < 256; w++) begin
            applyStimulus(randVec());
        end
        checkOutput("wc_saturated", int'(bus.window_count), 255);
        e = last_res;
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("final_ac_red", int'(bus.ac_red), int'(e.ac_red));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
